// File: rtl/note_tone_if.sv
// Note stream in, speaker drive and status out, between a song note source
// and the tone player.
interface note_tone_if;
    logic [6:0] note;
    logic       speaker;
    logic       playing;
    logic [3:0] octave;

    modport master (output note, input speaker, playing, octave);
    modport slave  (input note, output speaker, playing, octave);
endinterface

// File: rtl/note_tone_player.sv
// Turns a 7-bit note index into a 50 % duty square wave: octave/semitone split by
// repeated subtraction, one-octave half-period table, articulation gap, then tone.
module note_tone_player #(
    parameter int CLK_HZ     = 100000000,
    parameter int GAP_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    note_tone_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, DIVIDE, LOAD, GAP, PLAY} state_t;

    // Octave-0 half period for semitone s (MIDI 69 = 440 Hz), rounded to nearest.
    function automatic logic [22:0] base_hp(input int s);
        real f;
        f = 440.0 * (2.0 ** ((s - 69) / 12.0));
        return 23'($rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5));
    endfunction

    function automatic logic [22:0] clamp_hp(input logic [22:0] v);
        return (v < 23'd2) ? 23'd2 : v;
    endfunction

    logic [22:0] base_tbl [12];

    for (genvar g = 0; g < 12; g++) begin : g_tbl
        localparam logic [22:0] HP = base_hp(g);
        assign base_tbl[g] = HP;
    end

    state_t      state, state_nxt;
    logic [6:0]  cur_note;
    logic [6:0]  rem;
    logic [3:0]  oct;
    logic [22:0] hp;
    logic [22:0] cnt;
    logic [31:0] gcnt;
    logic        started;
    logic        chg;
    logic        spk_nxt;
    logic        play_nxt;

    assign chg = (bus.note != cur_note);

    // A note change pre-empts whatever is in progress.
    always_comb begin
        state_nxt = state;
        if (chg) begin
            state_nxt = DIVIDE;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                DIVIDE:  if (rem < 7'd12) state_nxt = LOAD;
                LOAD:    state_nxt = (GAP_CYCLES == 0) ? PLAY : GAP;
                GAP:     if (gcnt == '0) state_nxt = PLAY;
                PLAY:    state_nxt = PLAY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A change in the same cycle as a toggle forces silence rather than the toggle.
    always_comb begin
        spk_nxt  = 1'b0;
        play_nxt = 1'b0;
        if (!chg && state == PLAY && cur_note != 7'd0) begin
            play_nxt = 1'b1;
            if (!started)
                spk_nxt = 1'b1;
            else if (cnt == '0)
                spk_nxt = ~bus.speaker;
            else
                spk_nxt = bus.speaker;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cur_note    <= '0;
            rem         <= '0;
            oct         <= '0;
            hp          <= '0;
            cnt         <= '0;
            gcnt        <= '0;
            started     <= 1'b0;
            bus.speaker <= 1'b0;
            bus.playing <= 1'b0;
            bus.octave  <= '0;
        end else begin
            state       <= state_nxt;
            bus.speaker <= spk_nxt;
            bus.playing <= play_nxt;
            if (chg) begin
                cur_note <= bus.note;
                rem      <= bus.note;
                oct      <= '0;
                started  <= 1'b0;
            end else begin
                case (state)
                    DIVIDE: begin
                        if (rem >= 7'd12) begin
                            rem <= rem - 7'd12;
                            oct <= oct + 4'd1;
                        end
                    end
                    LOAD: begin
                        hp         <= clamp_hp(base_tbl[rem[3:0]] >> oct);
                        bus.octave <= oct;
                        gcnt       <= 32'(GAP_CYCLES) - 32'd1;
                    end
                    GAP: begin
                        if (gcnt != '0) gcnt <= gcnt - 32'd1;
                    end
                    PLAY: begin
                        if (cur_note != 7'd0) begin
                            if (!started) begin
                                started <= 1'b1;
                                cnt     <= hp - 23'd1;
                            end else if (cnt == '0) begin
                                cnt <= hp - 23'd1;
                            end else begin
                                cnt <= cnt - 23'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
